// File: rtl/cla_nibble_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_sequencer_if
// Purpose  : Request, adder-side and result signals of the nibble sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface cla_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_sequencer
// Purpose  : Feeds a wide add through a 4-bit registered adder, LS nibble first.
// Revision : 1.0 - initial release
// ============================================================================
module cla_nibble_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 2
) (
    input wire                     clk,
    input wire                     rst_n,
    cla_nibble_sequencer_if.slave  bus
);

    localparam int C_NIBBLES = WIDTH / 4;
    localparam int C_IDX_W   = (C_NIBBLES > 1) ? $clog2(C_NIBBLES) : 1;
    localparam int C_CNT_W   = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX  = C_IDX_W'(C_NIBBLES - 1);
    localparam logic [C_CNT_W-1:0] C_WAIT_INIT = C_CNT_W'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [C_IDX_W-1:0] r_idx;
    logic [C_CNT_W-1:0] r_wait_cnt;
    logic [WIDTH-1:0]   r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_carry     <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh     <= bus.in_a;
                        r_b_sh     <= bus.in_b;
                        r_carry    <= bus.in_cin;
                        r_a_msb    <= bus.in_a[WIDTH-1];
                        r_b_msb    <= bus.in_b[WIDTH-1];
                        r_result   <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= C_WAIT_INIT;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end else begin
                        // Adder output is only trusted on this edge; inputs were held since ISSUE.
                        for (int n = 0; n < C_NIBBLES; n++) begin
                            if (r_idx == C_IDX_W'(n)) begin
                                r_result[4*n +: 4] <= bus.add_sum;
                            end
                        end
                        r_carry <= bus.add_cout;
                        r_a_sh  <= r_a_sh >> 4;
                        r_b_sh  <= r_b_sh >> 4;
                        if (r_idx == C_LAST_IDX) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.add_a     = r_a_sh[3:0];
    assign bus.add_b     = r_b_sh[3:0];
    assign bus.add_cin   = r_carry;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_result;
    assign bus.out_cout  = r_carry;
    assign bus.out_ovf   = (r_a_msb == r_b_msb) && (r_result[WIDTH-1] != r_a_msb);

endmodule
`default_nettype wire
